// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and default sizing shared by the debounce timer
// and the button FSM instances that sit beside it.
package debounce_pkg;

    // 1 ms ticks at 50 MHz, hold periods up to 255 ticks
    localparam int unsigned DEF_PRESCALE = 50000;
    localparam int unsigned DEF_PERIOD_W = 8;

    // Timer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Counter width for a modulo-n prescaler; never narrower than one bit so a
    // divide-by-one prescaler still elaborates.
    function automatic int unsigned ps_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running modulo-PRESCALE prescaler with a synchronous clear.
// tick is high for the single cycle in which the count wraps back to zero, so
// with clr low the first tick after a clear lands PRESCALE edges later.
module tick_gen
    import debounce_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned         CNT_W = ps_width(PRESCALE);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]    ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    // Next prescaler count: cleared while clr is high, otherwise counts 0..LAST.
    always_comb begin
        wrap  = !clr && (cnt_q == LAST);
        cnt_d = cnt_q + ONE;
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    assign tick = wrap;

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debounce_timer.sv
// debounce_timer: hold-time responder for one push-button debounce FSM.
// The button FSM drops time_clr to start a run; after PRESCALE*max(period,1)
// clock edges time_done rises and stays high until time_clr returns high.
// Optional feature macro: DEBOUNCE_TIMER_ELAPSED_EN adds the elapsed output.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | time_clr high (or just finished); counters held at zero
//   RUN     | counting prescaled ticks toward the latched period P
//   DONE    | P ticks elapsed; time_done held until time_clr goes high
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                time_clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                time_done,
    output logic                time_busy
`ifdef DEBOUNCE_TIMER_ELAPSED_EN
    ,
    output logic [PERIOD_W-1:0] elapsed
`endif
);

    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    logic [1:0]          state_q,    state_d;
    logic [PERIOD_W-1:0] period_q,   period_d;
    logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic                done_q,     done_d;
    logic                busy_q,     busy_d;
    logic [PERIOD_W-1:0] tick_inc;
    logic                presc_clr;
    logic                tick;

    // The prescaler only runs in RUN with time_clr low, so every run starts
    // from a zero prescaler and an abort leaves it cleared.
    assign presc_clr = (state_q != ST_RUN) || time_clr;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (presc_clr),
        .tick    (tick)
    );

    assign tick_inc = tick_cnt_q + ONE_P;

    // FSM next state, period latch and tick counter; an abort on a wrap edge
    // takes priority because time_clr is tested before the tick.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        tick_cnt_d = tick_cnt_q;
        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (!time_clr) begin
                    state_d  = ST_RUN;
                    period_d = (period == '0) ? ONE_P : period;
                end
            end
            ST_RUN: begin
                if (time_clr) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    tick_cnt_d = tick_inc;
                    if (tick_inc == period_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (time_clr) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_RUN);
    end

    // State, period latch, tick counter and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            period_q   <= ONE_P;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign time_done = done_q;
    assign time_busy = busy_q;

`ifdef DEBOUNCE_TIMER_ELAPSED_EN
    // The tick counter already reads 0 in IDLE, the live count in RUN and P in DONE.
    assign elapsed = tick_cnt_q;
`endif

endmodule
